// File: rtl/message_scroller_if.sv
// Write port into the message store plus the display window returned to the LED driver.
interface message_scroller_if #(
  parameter int MSG_LEN = 16
) ();
  localparam int PTR_W = $clog2(MSG_LEN);

  logic             wr_en;
  logic [PTR_W-1:0] wr_addr;
  logic [3:0]       wr_data;
  logic [15:0]      ch;
  logic [PTR_W-1:0] ptr;
  logic             step;

  modport master (
    output wr_en, wr_addr, wr_data,
    input  ch, ptr, step
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    output ch, ptr, step
  );
endinterface

// File: rtl/message_scroller.sv
// Scrolls a 4-character window over a writable message on debounced button presses.
// Optional auto-scroll timer is compiled in when AUTO_SCROLL_EN is defined.
module message_scroller #(
  parameter int MSG_LEN         = 16,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SCROLL_PERIOD   = 50000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn,
  message_scroller_if.slave bus
);
  localparam int PTR_W = $clog2(MSG_LEN);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [PTR_W:0]   LEN      = (PTR_W+1)'(MSG_LEN);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MSG_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (MSG_LEN < 4 || MSG_LEN > 64) begin : g_bad_len
    $error("message_scroller: MSG_LEN must be 4..64");
  end
  if (DEBOUNCE_CYCLES < 2 || SCROLL_PERIOD < 2) begin : g_bad_timing
    $error("message_scroller: DEBOUNCE_CYCLES and SCROLL_PERIOD must be >= 2");
  end

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} db_state_t;

  db_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             s1, s2;
  logic             press, tick, adv;
  logic [PTR_W-1:0] ptr;
  logic [15:0]      ch, win;
  logic [3:0]       mem [MSG_LEN];

  always_ff @(posedge clk) begin
    if (reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      state <= IDLE;
      cnt   <= '0;
    end else begin
      s1    <= btn;
      s2    <= s1;
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // A bounce back to the previous level restarts the wait; only a full stable run is accepted.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    press     = 1'b0;
    case (state)
      IDLE: begin
        if (s2) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s2) begin
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_nxt = HELD;
          press     = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      HELD: begin
        if (!s2) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (s2) begin
          state_nxt = HELD;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef AUTO_SCROLL_EN
  localparam int TMR_W = $clog2(SCROLL_PERIOD);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SCROLL_PERIOD - 1);

  logic [TMR_W-1:0] timer;

  assign tick = (timer == TMR_LAST);

  // A press restarts the period so the next auto step is a full period away.
  always_ff @(posedge clk) begin
    if (reset || press || tick) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end
`else
  assign tick = 1'b0;
`endif

  assign adv = press | tick;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (adv) begin
      ptr <= (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MSG_LEN; i++) begin
        mem[i] <= 4'(i % 16);
      end
    end else if (bus.wr_en && ({1'b0, bus.wr_addr} < LEN)) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  function automatic logic [PTR_W-1:0] idx_add(input logic [PTR_W-1:0] base, input int unsigned k);
    logic [PTR_W:0] s;
    s = {1'b0, base} + (PTR_W+1)'(k);
    if (s >= LEN) begin
      s = s - LEN;
    end
    return s[PTR_W-1:0];
  endfunction

  always_comb begin
    win = '0;
    for (int k = 0; k < 4; k++) begin
      win[15-4*k -: 4] = mem[idx_add(ptr, k)];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ch <= 16'h0123;
    end else begin
      ch <= win;
    end
  end

  assign bus.ch   = ch;
  assign bus.ptr  = ptr;
  assign bus.step = adv;
endmodule

// File: tb/tb_message_scroller.sv
// Directed bench: a 16-entry and a 12-entry scroller share one button; vectors check step/ptr/ch per cycle.
module tb_message_scroller;
  logic clk = 1'b0;
  logic reset;
  logic btn;

  message_scroller_if #(.MSG_LEN(16)) if16 ();
  message_scroller_if #(.MSG_LEN(12)) if12 ();

  message_scroller #(.MSG_LEN(16), .DEBOUNCE_CYCLES(4), .SCROLL_PERIOD(20)) u16 (
    .clk(clk), .reset(reset), .btn(btn), .bus(if16)
  );
  message_scroller #(.MSG_LEN(12), .DEBOUNCE_CYCLES(4), .SCROLL_PERIOD(20)) u12 (
    .clk(clk), .reset(reset), .btn(btn), .bus(if12)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          n;
    logic        btn;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [3:0]  wr_data;
    logic        step;
    logic [3:0]  ptr;
    logic [15:0] ch;
  } vec_t;

  vec_t       vecs[$];
  int         vectors = 0;
  int         miscompares = 0;
  logic [3:0] m16 [16];
  logic [3:0] m12 [12];
  int         p16 = 0;
  int         p12 = 0;

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input int n, input logic b, input logic we, input logic [3:0] a,
                              input logic [3:0] d, input logic s, input logic [3:0] p,
                              input logic [15:0] c);
    vec_t v;
    v.n = n; v.btn = b; v.wr_en = we; v.wr_addr = a; v.wr_data = d;
    v.step = s; v.ptr = p; v.ch = c;
    return v;
  endfunction

  function automatic logic [15:0] win16(input int p);
    return {m16[p], m16[(p+1)%16], m16[(p+2)%16], m16[(p+3)%16]};
  endfunction

  function automatic logic [15:0] win12(input int p);
    return {m12[p], m12[(p+1)%12], m12[(p+2)%12], m12[(p+3)%12]};
  endfunction

  task automatic run_window(input int n, output int first, output int count);
    first = -1;
    count = 0;
    for (int i = 0; i < n; i++) begin
      if (if16.step) begin
        count++;
        if (first < 0) first = i;
      end
      nxt();
    end
  endtask

  task automatic press_once();
    int s16 = 0;
    int s12 = 0;
    btn = 1'b1;
    for (int i = 0; i < 22; i++) begin
      if (i == 12) btn = 1'b0;
      if (if16.step) s16++;
      if (if12.step) s12++;
      nxt();
    end
    p16 = (p16 + 1) % 16;
    p12 = (p12 + 1) % 12;
    chk("press_steps16", 32'(s16), 32'd1);
    chk("press_steps12", 32'(s12), 32'd1);
    chk("press_ptr16", 32'(if16.ptr), 32'(p16));
    chk("press_ptr12", 32'(if12.ptr), 32'(p12));
    chk("press_ch16", 32'(if16.ch), 32'(win16(p16)));
    chk("press_ch12", 32'(if12.ch), 32'(win12(p12)));
  endtask

  initial begin
    int first;
    int count;
    reset = 1'b1;
    btn = 1'b0;
    if16.wr_en = 1'b0; if16.wr_addr = '0; if16.wr_data = '0;
    if12.wr_en = 1'b0; if12.wr_addr = '0; if12.wr_data = '0;
    for (int i = 0; i < 16; i++) m16[i] = 4'(i);
    for (int i = 0; i < 12; i++) m12[i] = 4'(i);

    repeat (3) nxt();
    chk("reset_ch", 32'(if16.ch), 32'h0123);
    chk("reset_ptr", 32'(if16.ptr), 32'd0);
    chk("reset_step", 32'(if16.step), 32'd0);
    chk("reset_ch12", 32'(if12.ch), 32'h0123);
    reset = 1'b0;

`ifndef AUTO_SCROLL_EN
    run_window(30, first, count);
    chk("idle_no_step", 32'(count), 32'd0);

    vecs.push_back(mk(6,  1, 0, 0, 0,    0, 0, 16'h0123));
    vecs.push_back(mk(1,  1, 0, 0, 0,    1, 0, 16'h0123));
    vecs.push_back(mk(1,  1, 0, 0, 0,    0, 1, 16'h0123));
    vecs.push_back(mk(12, 1, 0, 0, 0,    0, 1, 16'h1234));
    vecs.push_back(mk(10, 0, 0, 0, 0,    0, 1, 16'h1234));
    vecs.push_back(mk(6,  1, 0, 0, 0,    0, 1, 16'h1234));
    vecs.push_back(mk(1,  1, 0, 0, 0,    1, 1, 16'h1234));
    vecs.push_back(mk(1,  1, 0, 0, 0,    0, 2, 16'h1234));
    vecs.push_back(mk(2,  1, 0, 0, 0,    0, 2, 16'h2345));
    vecs.push_back(mk(10, 0, 0, 0, 0,    0, 2, 16'h2345));
    vecs.push_back(mk(3,  1, 0, 0, 0,    0, 2, 16'h2345));
    vecs.push_back(mk(3,  0, 0, 0, 0,    0, 2, 16'h2345));
    vecs.push_back(mk(3,  1, 0, 0, 0,    0, 2, 16'h2345));
    vecs.push_back(mk(8,  0, 0, 0, 0,    0, 2, 16'h2345));
    vecs.push_back(mk(1,  0, 1, 3, 4'hA, 0, 2, 16'h2345));
    vecs.push_back(mk(1,  0, 0, 0, 0,    0, 2, 16'h2345));
    vecs.push_back(mk(2,  0, 0, 0, 0,    0, 2, 16'h2A45));
    vecs.push_back(mk(1,  0, 1, 3, 4'h3, 0, 2, 16'h2A45));
    vecs.push_back(mk(1,  0, 0, 0, 0,    0, 2, 16'h2A45));
    vecs.push_back(mk(1,  0, 0, 0, 0,    0, 2, 16'h2345));

    foreach (vecs[v]) begin
      for (int c = 0; c < vecs[v].n; c++) begin
        btn = vecs[v].btn;
        if16.wr_en = vecs[v].wr_en;
        if16.wr_addr = vecs[v].wr_addr;
        if16.wr_data = vecs[v].wr_data;
        chk($sformatf("vec%0d_step", v), 32'(if16.step), 32'(vecs[v].step));
        chk($sformatf("vec%0d_ptr", v), 32'(if16.ptr), 32'(vecs[v].ptr));
        chk($sformatf("vec%0d_ch", v), 32'(if16.ch), 32'(vecs[v].ch));
        nxt();
      end
    end
    if16.wr_en = 1'b0;
    p16 = 2;
    p12 = 2;

    // Out-of-range addresses on the 12-entry build must leave the store untouched.
    for (int a = 12; a < 16; a++) begin
      if12.wr_en = 1'b1;
      if12.wr_addr = 4'(a);
      if12.wr_data = 4'hF;
      nxt();
    end
    if12.wr_addr = 4'd11;
    if12.wr_data = 4'hE;
    nxt();
    m12[11] = 4'hE;
    if12.wr_en = 1'b0;
    nxt();
    chk("oor_write_ch12", 32'(if12.ch), 32'h2345);

    while (p16 != 15) press_once();
    chk("wrap_ptr15", 32'(if16.ptr), 32'd15);
    chk("wrap_ch_f012", 32'(if16.ch), 32'hF012);
    press_once();
    chk("wrap_ptr0", 32'(if16.ptr), 32'd0);
    chk("wrap_ch_0123", 32'(if16.ch), 32'h0123);

    if16.wr_en = 1'b1; if16.wr_addr = 4'd2; if16.wr_data = 4'hA;
    chk("wr_t0_ch", 32'(if16.ch), 32'h0123);
    nxt();
    if16.wr_en = 1'b0;
    chk("wr_t1_ch", 32'(if16.ch), 32'h0123);
    nxt();
    chk("wr_t2_ch", 32'(if16.ch), 32'h01A3);
    m16[2] = 4'hA;

    btn = 1'b1;
    repeat (6) nxt();
    chk("wradv_step", 32'(if16.step), 32'd1);
    if16.wr_en = 1'b1; if16.wr_addr = 4'd4; if16.wr_data = 4'hB;
    nxt();
    if16.wr_en = 1'b0;
    chk("wradv_ptr", 32'(if16.ptr), 32'd1);
    nxt();
    chk("wradv_ch", 32'(if16.ch), 32'h1A3B);
    btn = 1'b0;
    repeat (10) nxt();

    btn = 1'b1;
    repeat (4) nxt();
    reset = 1'b1;
    nxt();
    chk("rst_mid_step", 32'(if16.step), 32'd0);
    nxt();
    reset = 1'b0;
    chk("rst_mid_ptr", 32'(if16.ptr), 32'd0);
    chk("rst_mid_ch", 32'(if16.ch), 32'h0123);
    run_window(12, first, count);
    chk("rst_mid_first_step", 32'(first), 32'd6);
    chk("rst_mid_step_count", 32'(count), 32'd1);
    btn = 1'b0;
    repeat (10) nxt();
`else
    run_window(20, first, count);
    chk("auto_first_tick", 32'(first), 32'd19);
    chk("auto_first_count", 32'(count), 32'd1);
    run_window(20, first, count);
    chk("auto_second_tick", 32'(first), 32'd19);
    chk("auto_ptr2", 32'(if16.ptr), 32'd2);
    run_window(13, first, count);
    chk("auto_quiet", 32'(count), 32'd0);
    btn = 1'b1;
    run_window(7, first, count);
    chk("auto_coincide_at", 32'(first), 32'd6);
    chk("auto_coincide_count", 32'(count), 32'd1);
    chk("auto_coincide_ptr", 32'(if16.ptr), 32'd3);
    btn = 1'b0;
    run_window(20, first, count);
    chk("auto_after_press_tick", 32'(first), 32'd19);
    chk("auto_after_press_count", 32'(count), 32'd1);
    chk("auto_ptr4", 32'(if16.ptr), 32'd4);
    run_window(15, first, count);
    chk("auto_pre_reset_quiet", 32'(count), 32'd0);
    reset = 1'b1;
    nxt();
    reset = 1'b0;
    run_window(20, first, count);
    chk("auto_post_reset_tick", 32'(first), 32'd19);
    chk("auto_post_reset_count", 32'(count), 32'd1);
    chk("auto_post_reset_ptr", 32'(if16.ptr), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
